// File: rtl/ysyx_25030085_pkg.sv
// Shared types and defaults for the IFU/LSU data-memory arbiter.
package ysyx_25030085_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/ysyx_25030085_arb_timer.sv
// Response watchdog: cleared on entry to WAIT, counts WAIT cycles, flags when LIMIT is reached.
module ysyx_25030085_arb_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_25030085_mem_arbiter.sv
// Shares one data-memory port between IFU and LSU; LSU wins ties, one transaction in flight.
// Define MEM_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYC cycles.
module ysyx_25030085_mem_arbiter
    import ysyx_25030085_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                timeout_err
);

    localparam int unsigned MASK_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wen_q,   wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;

    logic in_idle, in_wait;
    logic lsu_grant, ifu_grant;
    logic rsp_fire, timeout_fire, done;
    logic wait_expired;

    // Reset masks every handshake so nothing leaks out during the reset cycle itself.
    assign in_idle      = (state_q == IDLE) & ~rst;
    assign in_wait      = (state_q == WAIT) & ~rst;
    assign lsu_grant    = in_idle & lsu_req_valid;
    assign ifu_grant    = in_idle & ifu_req_valid & ~lsu_req_valid;
    assign rsp_fire     = in_wait & mem_rsp_valid;
    assign timeout_fire = in_wait & wait_expired & ~mem_rsp_valid;
    assign done         = rsp_fire | timeout_fire;

    always_comb begin
        // NOTE: every target gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        unique case (state_q)
            IDLE: begin
                if (lsu_grant) begin
                    state_d = ISSUE;
                    owner_d = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                end else if (ifu_grant) begin
                    state_d = ISSUE;
                    owner_d = OWN_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '1;
                end
            end
            ISSUE: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign lsu_req_ready = lsu_grant;
    assign ifu_req_ready = ifu_grant;

    assign mem_req_valid = (state_q == ISSUE) & ~rst;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // A timed-out response still completes the owner's handshake, but with zero data.
    assign ifu_rsp_valid = done & (owner_q == OWN_IFU);
    assign lsu_rsp_valid = done & (owner_q == OWN_LSU);
    assign ifu_rdata     = (rsp_fire && owner_q == OWN_IFU) ? mem_rdata : '0;
    assign lsu_rdata     = (rsp_fire && owner_q == OWN_LSU) ? mem_rdata : '0;

`ifdef MEM_TIMEOUT_EN
    ysyx_25030085_arb_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state_q == ISSUE) & mem_req_ready),
        .en      (state_q == WAIT),
        .expired (wait_expired)
    );
    assign timeout_err = timeout_fire;
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_25030085_mem_arbiter.sv
// Directed self-checking bench for the IFU/LSU memory arbiter; honours MEM_TIMEOUT_EN (TIMEOUT_CYC=4).
module tb_ysyx_25030085_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_25030085_mem_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .timeout_err   (timeout_err)
    );

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ifu_req_valid = 1'b0; ifu_addr  = '0;
        lsu_req_valid = 1'b0; lsu_addr  = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    endtask

    // Stimulus only: completes a transaction currently in ISSUE with a zero-latency memory.
    task automatic finish_txn;
        mem_req_ready = 1'b1;
        next_cyc();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0;
        next_cyc();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_rsp_valid = 1'b1;
        next_cyc();
        @(negedge clk);
        n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b expected 00", {ifu_req_ready, lsu_req_ready}); end
        n_checks++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, timeout_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_valids: got %b expected 0000", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, timeout_err}); end
        next_cyc();
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_fail++; $display("FAIL rst_fields: got %h expected 0", {mem_addr, mem_wdata}); end
        n_checks++; if ({mem_wen, mem_wmask} !== 5'b0) begin n_fail++; $display("FAIL rst_wen_mask: got %b expected 00000", {mem_wen, mem_wmask}); end
        n_checks++; if ({ifu_rdata, lsu_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", {ifu_rdata, lsu_rdata}); end
        next_cyc();
    endtask

    task automatic test_ifu_only;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        @(negedge clk);
        n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin n_fail++; $display("FAIL t1_grant: got %b expected 10", {ifu_req_ready, lsu_req_ready}); end
        next_cyc();
        ifu_req_valid = 1'b0; ifu_addr = 32'h0; mem_req_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL t1_mem_req: got %b expected 1", mem_req_valid); end
        n_checks++; if ({mem_addr, mem_wen, mem_wmask} !== {32'h8000_0000, 1'b0, 4'hf}) begin n_fail++; $display("FAIL t1_fields: got %h/%b/%h expected 80000000/0/f", mem_addr, mem_wen, mem_wmask); end
        next_cyc();
        mem_req_ready = 1'b0;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            n_checks++; if ({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL t1_wait%0d: got %b expected 000", w, {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}); end
            next_cyc();
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        @(negedge clk);
        n_checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL t1_rsp: got %b expected 10", {ifu_rsp_valid, lsu_rsp_valid}); end
        n_checks++; if (ifu_rdata !== 32'h0000_0413) begin n_fail++; $display("FAIL t1_rdata: got %h expected 00000413", ifu_rdata); end
        next_cyc();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({ifu_rsp_valid, ifu_rdata} !== 33'h0) begin n_fail++; $display("FAIL t1_pulse: got %b/%h expected 0/0", ifu_rsp_valid, ifu_rdata); end
        next_cyc();
    endtask

    task automatic test_priority;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hf;
        @(negedge clk);
        n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin n_fail++; $display("FAIL t2_grant: got %b expected 01", {ifu_req_ready, lsu_req_ready}); end
        next_cyc();
        lsu_req_valid = 1'b0; lsu_wdata = 32'h0; mem_req_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({mem_addr, mem_wdata} !== {32'h8000_1000, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL t2_fields: got %h/%h expected 80001000/deadbeef", mem_addr, mem_wdata); end
        n_checks++; if ({mem_wen, mem_wmask, ifu_req_ready} !== 6'b1_1111_0) begin n_fail++; $display("FAIL t2_wen_mask: got %b expected 111110", {mem_wen, mem_wmask, ifu_req_ready}); end
        next_cyc();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        n_checks++; if ({lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready} !== 3'b100) begin n_fail++; $display("FAIL t2_lsu_rsp: got %b expected 100", {lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready}); end
        next_cyc();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({ifu_req_ready, lsu_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL t2_ifu_grant: got %b expected 10", {ifu_req_ready, lsu_rsp_valid}); end
        next_cyc();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({mem_addr, mem_wen, mem_wmask} !== {32'h8000_0004, 1'b0, 4'hf}) begin n_fail++; $display("FAIL t2_ifu_fields: got %h/%b/%h expected 80000004/0/f", mem_addr, mem_wen, mem_wmask); end
        next_cyc();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++; if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rdata, lsu_rdata} !== {2'b10, 32'h1234_5678, 32'h0}) begin n_fail++; $display("FAIL t2_ifu_rsp: got %b%b/%h/%h expected 10/12345678/0", ifu_rsp_valid, lsu_rsp_valid, ifu_rdata, lsu_rdata); end
        next_cyc();
        clear_inputs();
    endtask

    task automatic test_issue_stall;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2002; lsu_wen = 1'b1;
        lsu_wdata = 32'h00AB_0000; lsu_wmask = 4'b0100;
        next_cyc();
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        for (int i = 0; i < 3; i++) begin
            lsu_req_valid = (i == 1);
            @(negedge clk);
            n_checks++; if ({mem_req_valid, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 32'h8000_2002, 32'h00AB_0000, 4'b0100}) begin n_fail++; $display("FAIL t3_hold%0d: got %b/%h/%h/%b expected 1/80002002/00ab0000/0100", i, mem_req_valid, mem_addr, mem_wdata, mem_wmask); end
            n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin n_fail++; $display("FAIL t3_nogrant%0d: got %b expected 00", i, {ifu_req_ready, lsu_req_ready}); end
            next_cyc();
        end
        lsu_req_valid = 1'b0;
        finish_txn();
        @(negedge clk);
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL t3_ifu_after: got %b expected 1", ifu_req_ready); end
        next_cyc();
        ifu_req_valid = 1'b0;
        finish_txn();
    endtask

    task automatic test_spurious_rsp;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_rdata, lsu_rdata} !== 67'h0) begin n_fail++; $display("FAIL t4_idle%0d: got %b%b%b/%h/%h expected 000/0/0", i, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_rdata, lsu_rdata); end
            next_cyc();
        end
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080;
        @(negedge clk);
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL t4_still_idle: got %b expected 1", ifu_req_ready); end
        next_cyc();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({ifu_rsp_valid, mem_req_valid} !== 2'b01) begin n_fail++; $display("FAIL t4_issue: got %b expected 01", {ifu_rsp_valid, mem_req_valid}); end
        next_cyc();
        mem_rsp_valid = 1'b0;
        finish_txn();
    endtask

    task automatic test_reset_in_wait;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        next_cyc();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        next_cyc();
        mem_req_ready = 1'b0; rst = 1'b1;
        next_cyc();
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        n_checks++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_rdata} !== 35'h0) begin n_fail++; $display("FAIL t5_dropped: got %b%b%b/%h expected 000/0", ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_rdata); end
        n_checks++; if ({mem_addr, mem_wmask} !== 36'h0) begin n_fail++; $display("FAIL t5_fields: got %h/%h expected 0/0", mem_addr, mem_wmask); end
        next_cyc();
        mem_rsp_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        @(negedge clk);
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL t5_regrant: got %b expected 1", ifu_req_ready); end
        next_cyc();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL t5_addr: got %h expected 80000010", mem_addr); end
        next_cyc();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0010_0073;
        @(negedge clk);
        n_checks++; if ({ifu_rsp_valid, ifu_rdata} !== {1'b1, 32'h0010_0073}) begin n_fail++; $display("FAIL t5_rsp: got %b/%h expected 1/00100073", ifu_rsp_valid, ifu_rdata); end
        next_cyc();
        clear_inputs();
    endtask

    task automatic test_timeout;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0020; lsu_wen = 1'b0; lsu_wmask = 4'hf;
        next_cyc();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        next_cyc();
        mem_req_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            n_checks++; if ({timeout_err, lsu_rsp_valid, ifu_rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL t6_wait%0d: got %b expected 000", w, {timeout_err, lsu_rsp_valid, ifu_rsp_valid}); end
            next_cyc();
        end
`ifdef MEM_TIMEOUT_EN
        @(negedge clk);
        n_checks++; if ({timeout_err, lsu_rsp_valid, ifu_rsp_valid} !== 3'b110) begin n_fail++; $display("FAIL t6_abort: got %b expected 110", {timeout_err, lsu_rsp_valid, ifu_rsp_valid}); end
        n_checks++; if (lsu_rdata !== 32'h0) begin n_fail++; $display("FAIL t6_rdata: got %h expected 0", lsu_rdata); end
        next_cyc();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0024;
        @(negedge clk);
        n_checks++; if ({timeout_err, lsu_rsp_valid, ifu_req_ready} !== 3'b001) begin n_fail++; $display("FAIL t6_after: got %b expected 001", {timeout_err, lsu_rsp_valid, ifu_req_ready}); end
        next_cyc();
        ifu_req_valid = 1'b0;
        finish_txn();
`else
        for (int w = 4; w < 7; w++) begin
            @(negedge clk);
            n_checks++; if ({timeout_err, lsu_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL t6_hold%0d: got %b expected 00", w, {timeout_err, lsu_rsp_valid}); end
            next_cyc();
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_5a5a;
        @(negedge clk);
        n_checks++; if ({lsu_rsp_valid, lsu_rdata, timeout_err} !== {1'b1, 32'h0000_5a5a, 1'b0}) begin n_fail++; $display("FAIL t6_late_rsp: got %b/%h/%b expected 1/00005a5a/0", lsu_rsp_valid, lsu_rdata, timeout_err); end
        next_cyc();
`endif
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ifu_only();
        test_priority();
        test_issue_stall();
        test_spurious_rsp();
        test_reset_in_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
